// File: rtl/seg_disp_sched.sv
// seg_disp_sched: arbitrates the digit display between the temperature path
// and the setting menu, paces din/din_vld so seg_disp finishes each capture
// walk, and blinks disp_en while a setting is edited.
module seg_disp_sched #(
  parameter int MAX_SMG_NUM = 6,
  parameter int HOLD_CNT    = 150_000_000,
  parameter int BLINK_CNT   = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MAX_SMG_NUM*4-1:0] temp_din,
  input  logic                     temp_vld,
  input  logic [MAX_SMG_NUM*4-1:0] set_din,
  input  logic                     set_vld,
  input  logic                     set_active,
  input  logic                     blink_en,
  output logic                     disp_en,
  output logic [MAX_SMG_NUM*4-1:0] din,
  output logic [MAX_SMG_NUM-1:0]   din_vld
);

  localparam int DW = MAX_SMG_NUM * 4;
  localparam int HW = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam int GW = $clog2(MAX_SMG_NUM + 2);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CNT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(MAX_SMG_NUM + 1);

  typedef enum logic [1:0] {S_TEMP, S_SET, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          temp_sh_q, temp_sh_d;
  logic [DW-1:0]          set_sh_q, set_sh_d;
  logic [DW-1:0]          last_sent_q, last_sent_d;
  logic [DW-1:0]          din_q, din_d;
  logic [MAX_SMG_NUM-1:0] din_vld_q, din_vld_d;
  logic                   disp_en_q, disp_en_d;
  logic                   pend_q, pend_d;
  logic                   full_q, full_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [BW-1:0]          blink_q, blink_d;

  logic                   full_set;
  logic                   sel_strobe;
  logic                   issue;
  logic [DW-1:0]          sel_sh;
  logic [MAX_SMG_NUM-1:0] mask;

  assign disp_en = disp_en_q;
  assign din     = din_q;
  assign din_vld = din_vld_q;

  // Next-state: shadows, ownership FSM, pending/issue pacing and blink.
  always_comb begin
    temp_sh_d   = temp_vld ? temp_din : temp_sh_q;
    set_sh_d    = set_vld ? set_din : set_sh_q;
    state_d     = state_q;
    hold_d      = '0;
    full_set    = 1'b0;

    case (state_q)
      S_TEMP: begin
        if (set_active) begin
          state_d  = S_SET;
          full_set = 1'b1;
        end
      end
      S_SET: begin
        if (!set_active) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (set_active) begin
          state_d = S_SET;
        end else if (hold_q == HOLD_LAST) begin
          state_d  = S_TEMP;
          full_set = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d  = S_TEMP;
        full_set = 1'b1;
      end
    endcase

    // A strobe is judged against the source owning the display after this edge.
    sel_strobe = (state_d == S_TEMP) ? temp_vld : set_vld;
    sel_sh     = (state_q == S_TEMP) ? temp_sh_q : set_sh_q;
    issue      = pend_q && (gap_q == '0);

    mask = '0;
    for (int unsigned i = 0; i < MAX_SMG_NUM; i++) begin
      mask[i] = full_q || (sel_sh[i*4 +: 4] != last_sent_q[i*4 +: 4]);
    end

    din_d       = din_q;
    din_vld_d   = '0;
    last_sent_d = last_sent_q;
    gap_d       = (gap_q != '0) ? gap_q - 1'b1 : '0;
    if (issue) begin
      last_sent_d = sel_sh;
      if (mask != '0) begin
        din_d     = sel_sh;
        din_vld_d = mask;
        gap_d     = GAP_LOAD;
      end
    end

    // Strobes landing in the issue cycle keep pend set for the next slot.
    pend_d = (pend_q && !issue) || sel_strobe || full_set;
    full_d = (full_q && !issue) || full_set;

    blink_d   = '0;
    disp_en_d = 1'b1;
    if (state_q == S_SET && blink_en) begin
      if (blink_q == BLINK_LAST) begin
        disp_en_d = !disp_en_q;
      end else begin
        blink_d   = blink_q + 1'b1;
        disp_en_d = disp_en_q;
      end
    end
  end

  // State registers; reset leaves a full refresh pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_TEMP;
      temp_sh_q   <= '0;
      set_sh_q    <= '0;
      last_sent_q <= '0;
      din_q       <= '0;
      din_vld_q   <= '0;
      disp_en_q   <= 1'b0;
      pend_q      <= 1'b1;
      full_q      <= 1'b1;
      gap_q       <= '0;
      hold_q      <= '0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      temp_sh_q   <= temp_sh_d;
      set_sh_q    <= set_sh_d;
      last_sent_q <= last_sent_d;
      din_q       <= din_d;
      din_vld_q   <= din_vld_d;
      disp_en_q   <= disp_en_d;
      pend_q      <= pend_d;
      full_q      <= full_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
    end
  end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Display scheduler in front of `seg_disp`. It arbitrates the six-digit display between two requesters: the live temperature path and the threshold-setting menu. It paces `din`/`din_vld` updates so `seg_disp` always finishes its 6-cycle digit capture walk before new data arrives. It also generates the `disp_en` blink used while a setting is being edited.

## Interface
- `MAX_SMG_NUM`, 6, number of digits; all data buses are `MAX_SMG_NUM*4` bits wide.
- `HOLD_CNT`, 150_000_000, cycles the setting view stays up after `set_active` falls (3 s at 50 MHz).
- `BLINK_CNT`, 25_000_000, cycles per `disp_en` half-period while blinking.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `temp_din`  in  24  temperature digits, nibble i = digit i.
- `temp_vld`  in  1  one-cycle strobe, `temp_din` valid.
- `set_din`  in  24  setting-menu digits.
- `set_vld`  in  1  one-cycle strobe, `set_din` valid.
- `set_active`  in  1  level, menu owns the display.
- `blink_en`  in  1  level, blink the display while in the setting view.
- `disp_en`  out  1  to `seg_disp`, display enable.
- `din`  out  24  to `seg_disp`, digit data.
- `din_vld`  out  6  to `seg_disp`, per-digit update mask; one-cycle pulse.

## Operation
- **Shadow registers.** `temp_sh` loads `temp_din` on every `temp_vld`, in any state. `set_sh` loads `set_din` on every `set_vld`, in any state. The selected source is `set_sh` in S_SET and S_HOLD, and `temp_sh` in S_TEMP.
- **States** (reset value S_TEMP):
  - S_TEMP → S_SET when `set_active`=1; sets full-refresh.
  - S_SET → S_HOLD when `set_active`=0; hold counter loads 0.
  - S_HOLD → S_SET when `set_active`=1; no refresh.
  - S_HOLD → S_TEMP when hold counter reaches HOLD_CNT-1; sets full-refresh.
- **Pending flag.** `pend` is set by:
  - a strobe of the selected source,
  - a state change that sets full-refresh,
  - reset (full-refresh is pending after reset).
- **Issue.** An issue happens when `pend`=1 and the gap counter is 0:
  - `din` ← selected shadow.
  - `din_vld`[i] ← 1 if full-refresh, or if nibble i of the selected shadow ≠ nibble i of `last_sent`.
  - `last_sent` ← selected shadow.
  - `pend` and full-refresh are cleared.
  - The gap counter loads MAX_SMG_NUM+1.
  - If the computed mask is 0, no pulse is issued and the gap counter is not loaded; `pend` still clears.
- **Coalescing.** Strobes arriving while the gap counter is nonzero only set `pend`. The latest shadow value wins; intermediate values are dropped.
- **Data hold.** `din` is held constant between issues.
- **Blink.** In S_SET with `blink_en`=1, the blink counter counts 0..BLINK_CNT-1 and wraps; `disp_en` toggles at each wrap. In any other state, or with `blink_en`=0, the blink counter clears and `disp_en`=1.

## Timing
- **Reset values:** `din`=0, `din_vld`=0, `disp_en`=0, state S_TEMP, shadows=0, `last_sent`=0, gap=0, hold=0, blink=0.
- **First cycles after reset release:**
  - `disp_en`=1 from the first edge after release.
  - The first edge also issues a full refresh: `din_vld`=6'h3F, `din`=0.
- **Latency.** A strobe sampled at edge k, with gap idle, gives a shadow update at edge k and `din`/`din_vld` visible after edge k+1, i.e. 2 cycles from strobe to pulse.
- **Pulse spacing.** For a pulse visible in cycle P:
  - the gap counter is nonzero in cycles P..P+MAX_SMG_NUM;
  - the earliest next pulse is cycle P+MAX_SMG_NUM+2 (P+8 by default).
- **Simultaneous events:**
  - `temp_vld` and `set_vld` in the same cycle: both shadows load.
  - A state change and a strobe in the same cycle: the issue uses the new state's source with a full refresh.
- **Hold window.** `set_active` re-rising in S_HOLD cancels the hold count; S_HOLD re-entry restarts the count from 0.
- **Blink edge cases:**
  - Leaving S_SET mid-blink forces `disp_en`=1 on the next edge.
  - Entering S_SET starts with `disp_en`=1 and the counter at 0.
- **Reset mid-walk.** Reset asserted while the gap counter is nonzero returns all outputs to reset values immediately.

## Test plan
- **Reset release:** release reset → next cycle `disp_en`=1, `din_vld`=6'h3F, `din`=0; then `din_vld`=0.
- **Partial update:** `temp_vld` with `temp_din`=24'h000253 → 2 cycles later `din`=24'h000253, `din_vld`=6'h07 for 1 cycle. Then `temp_din`=24'h000254 → `din_vld`=6'h01.
- **Coalescing:** 3 `temp_vld` strobes on consecutive cycles (values 24'h111111, 24'h222222, 24'h333333) → pulse 1 carries 24'h111111 with mask 6'h3F; pulse 2, exactly 8 cycles later, carries 24'h333333 with mask 6'h3F; no third pulse.
- **Source switch and hold:**
  - `set_active`=1 with `set_sh`=24'h000300 → full refresh with 24'h000300; `temp_vld` strobes produce no pulse.
  - Drop `set_active` → exactly HOLD_CNT cycles later (use small HOLD_CNT) a full refresh with the latest `temp_sh`.
- **Blink (BLINK_CNT=4):** `blink_en`=1 in S_SET → `disp_en` toggles every 4 cycles. `blink_en`=0 → `disp_en`=1 on the next edge and stays 1.
- **Mid-gap reset:** assert `rst_n`=0 two cycles after a pulse → `din`=0, `din_vld`=0, `disp_en`=0 immediately; after release, a full refresh occurs on the first edge.
